// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: polarity constants,
// NOP/zero words and the fetch FSM state encoding.
package if_fetch_pkg;

  localparam logic        RstEnable    = 1'b0;
  localparam logic        StallEnable  = 1'b1;
  localparam logic        StallDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [31:0] NopInst      = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_WAIT  = 2'b01,
    S_READY = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/if_pc_next.sv
// Combinational next-PC selection for the fetch stage.
// Priority: flush handler, fresh branch, pending redirect, sequential step.
module if_pc_next #(
  parameter int unsigned PC_STEP = 4
) (
  input  logic [31:0] i_pc,
  input  logic        i_redir_pend,
  input  logic [31:0] i_redir_pc,
  input  logic        i_branch_flag,
  input  logic [31:0] i_branch_target,
  input  logic        i_flush,
  input  logic [31:0] i_new_pc,
  output logic [31:0] o_next_pc
);

  always_comb begin
    o_next_pc = i_pc + 32'(PC_STEP);
    if (i_flush) begin
      o_next_pc = i_new_pc;
    end else if (i_branch_flag) begin
      o_next_pc = i_branch_target;
    end else if (i_redir_pend) begin
      o_next_pc = i_redir_pc;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch to instruction
// memory and presents if_pc/if_instr to IF/ID with delay-slot branch handling.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        stallreq_if
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [31:0] r_pc;
  logic        r_redir_pend;
  logic [31:0] r_redir_pc;
  logic        r_drop;
  logic [31:0] r_buf;
  logic        r_req;
  logic [31:0] r_addr;

  logic        w_handover;
  logic [31:0] w_next_pc;
  logic        w_unused_stall;

  assign w_unused_stall = ^stall[5:1];

  // The presented instruction is consumed on an edge where IF is not stalled.
  assign w_handover = (r_state == S_READY) && (stall[0] == StallDisable) && !flush;

  if_pc_next #(
    .PC_STEP(PC_STEP)
  ) u_pc_next (
    .i_pc            (r_pc),
    .i_redir_pend    (r_redir_pend),
    .i_redir_pc      (r_redir_pc),
    .i_branch_flag   (branch_flag_i),
    .i_branch_target (branch_target_i),
    .i_flush         (flush),
    .i_new_pc        (new_pc),
    .o_next_pc       (w_next_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: w_state_next = flush ? S_FETCH : S_WAIT;
      S_WAIT: begin
        // A flushed request still completes; its word is simply discarded.
        if (imem_ack) begin
          w_state_next = (r_drop || flush) ? S_FETCH : S_READY;
        end
      end
      S_READY: begin
        if (flush || (stall[0] == StallDisable)) begin
          w_state_next = S_FETCH;
        end
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req    = r_req;
    imem_addr   = r_addr;
    if_pc       = r_pc;
    if_instr    = NopInst;
    stallreq_if = StallEnable;
    if (r_state == S_READY) begin
      if_instr    = r_buf;
      stallreq_if = StallDisable;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_pc         <= RESET_PC;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= ZeroWord;
    end else if (flush || w_handover) begin
      r_pc         <= w_next_pc;
      r_redir_pend <= 1'b0;
    end else if (branch_flag_i) begin
      r_redir_pend <= 1'b1;
      r_redir_pc   <= branch_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_req  <= 1'b0;
      r_addr <= RESET_PC;
    end else if ((r_state == S_FETCH) && !flush) begin
      r_req  <= 1'b1;
      r_addr <= r_pc;
    end else if ((r_state == S_WAIT) && imem_ack) begin
      r_req  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_drop <= 1'b0;
      r_buf  <= ZeroWord;
    end else if (r_state == S_WAIT) begin
      if (imem_ack) begin
        r_drop <= 1'b0;
        if (!r_drop && !flush) begin
          r_buf <= imem_rdata;
        end
      end else if (flush) begin
        r_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by a randomized
// phase scored against a PC-sequence model with a latency-programmable memory.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush;
  logic [31:0] new_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        stallreq_if;

  int checks   = 0;
  int failures = 0;
  int ackDelay = 0;
  int waitCnt;

  logic [31:0] modelPc;
  logic        modelPend;
  logic [31:0] modelRedir;
  logic        prevReq;
  logic [31:0] prevAddr;
  logic [5:0]  rStall;
  logic        rBr;
  logic [31:0] rTgt;
  logic        handover;
  int          consumed;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush           (flush),
    .new_pc          (new_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .stallreq_if     (stallreq_if)
  );

  always #5 clk = ~clk;

  // Memory acks after ackDelay extra cycles of a held request.
  always @(posedge clk or negedge rst) begin
    if (!rst) waitCnt <= 0;
    else if (imem_req && !imem_ack) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  assign imem_ack   = imem_req && (waitCnt >= ackDelay);
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] st, input logic br, input logic [31:0] tgt,
                               input logic fl, input logic [31:0] npc);
    stall           = st;
    branch_flag_i   = br;
    branch_target_i = tgt;
    flush           = fl;
    new_pc          = npc;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady;
    for (int i = 0; i < 30 && stallreq_if; i++) begin
      checkOutput("idleNop", if_instr, 32'h0);
      tick();
    end
    checkOutput("readyInTime", {31'b0, stallreq_if}, 32'h0);
  endtask

  task automatic presentCheck(input logic [31:0] expPc);
    waitReady();
    checkOutput("ifPc", if_pc, expPc);
    checkOutput("ifInstr", if_instr, memWord(expPc));
  endtask

  task automatic checkResetValues;
    checkOutput("rstReq", {31'b0, imem_req}, 32'h0);
    checkOutput("rstAddr", imem_addr, 32'h0);
    checkOutput("rstIfPc", if_pc, 32'h0);
    checkOutput("rstInstr", if_instr, 32'h0);
    checkOutput("rstStallreq", {31'b0, stallreq_if}, 32'h1);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    checkResetValues();
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Zero-wait fetches: stallreq_if 1,1,0 with pc 0 then 4.
    for (int i = 0; i < 6; i++) begin
      checkOutput("stallPattern", {31'b0, stallreq_if}, ((i % 3) == 2) ? 32'd0 : 32'd1);
      if ((i % 3) == 2) begin
        checkOutput("seqPc", if_pc, 32'((i / 3) * 4));
        checkOutput("seqInstr", if_instr, memWord(32'((i / 3) * 4)));
      end
      if (i < 5) tick();
    end

    // Slow memory at pc 8: request and address held through the wait.
    ackDelay = 3;
    tick();
    checkOutput("fetchStallreq", {31'b0, stallreq_if}, 32'h1);
    tick();
    for (int k = 0; k < 4; k++) begin
      checkOutput("waitReq", {31'b0, imem_req}, 32'h1);
      checkOutput("waitAddr", imem_addr, 32'h8);
      checkOutput("waitStallreq", {31'b0, stallreq_if}, 32'h1);
      checkOutput("waitNop", if_instr, 32'h0);
      tick();
    end
    checkOutput("slowReady", {31'b0, stallreq_if}, 32'h0);
    checkOutput("slowPc", if_pc, 32'h8);
    checkOutput("slowInstr", if_instr, memWord(32'h8));
    ackDelay = 0;

    // Branch during the fetch of 0x10: delay slot issues, then target.
    tick();
    presentCheck(32'hC);
    tick();
    tick();
    checkOutput("brFetchAddr", imem_addr, 32'h10);
    applyStimulus(6'h0, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    applyStimulus(6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    presentCheck(32'h10);
    tick();
    presentCheck(32'h100);

    // Branch coincident with the handover of the delay slot.
    tick();
    presentCheck(32'h104);
    applyStimulus(6'h0, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    applyStimulus(6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    presentCheck(32'h200);

    // Flush while waiting on memory: the old word must never appear.
    tick();
    ackDelay = 2;
    tick();
    checkOutput("flushWaitAddr", imem_addr, 32'h204);
    applyStimulus(6'h0, 1'b0, 32'h0, 1'b1, 32'h180);
    tick();
    applyStimulus(6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("flushHoldReq", {31'b0, imem_req}, 32'h1);
    checkOutput("flushHoldAddr", imem_addr, 32'h204);
    presentCheck(32'h180);
    ackDelay = 0;

    // IF stall held in S_READY.
    applyStimulus(6'h1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("stallPc", if_pc, 32'h180);
      checkOutput("stallInstr", if_instr, memWord(32'h180));
      checkOutput("stallNoReq", {31'b0, imem_req}, 32'h0);
    end
    applyStimulus(6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    presentCheck(32'h184);

    // Flush coincident with ack: rdata discarded.
    tick();
    tick();
    applyStimulus(6'h0, 1'b0, 32'h0, 1'b1, 32'h1C0);
    tick();
    applyStimulus(6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("flushAckStallreq", {31'b0, stallreq_if}, 32'h1);
    checkOutput("flushAckReq", {31'b0, imem_req}, 32'h0);
    presentCheck(32'h1C0);

    // Asynchronous reset between edges while waiting.
    ackDelay = 3;
    tick();
    tick();
    checkOutput("preRstReq", {31'b0, imem_req}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    checkResetValues();
    @(negedge clk);
    rst = 1'b1;
    ackDelay = 0;
    #1;
    checkOutput("relNoReq", {31'b0, imem_req}, 32'h0);
    tick();
    checkOutput("relReq", {31'b0, imem_req}, 32'h1);
    checkOutput("relAddr", imem_addr, 32'h0);
    presentCheck(32'h0);

    // PC wrap at the top of the address space.
    applyStimulus(6'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    presentCheck(32'hFFFF_FFFC);
    tick();
    presentCheck(32'h0);

    // Randomized stalls, branches and memory latency against the PC model.
    modelPc    = 32'h0;
    modelPend  = 1'b0;
    modelRedir = 32'h0;
    prevReq    = 1'b0;
    prevAddr   = 32'h0;
    consumed   = 0;
    for (int n = 0; n < 600; n++) begin
      if (!stallreq_if) begin
        checkOutput("rndPc", if_pc, modelPc);
        checkOutput("rndInstr", if_instr, memWord(modelPc));
      end else begin
        checkOutput("rndNop", if_instr, 32'h0);
      end
      if (imem_req && prevReq) checkOutput("rndAddrHold", imem_addr, prevAddr);
      prevReq  = imem_req;
      prevAddr = imem_addr;
      if (!imem_req) ackDelay = $urandom_range(0, 3);
      rStall    = 6'($urandom);
      rStall[0] = ($urandom_range(0, 3) == 0);
      rBr       = ($urandom_range(0, 7) == 0);
      rTgt      = $urandom & 32'hFFFF_FFFC;
      applyStimulus(rStall, rBr, rTgt, 1'b0, 32'h0);
      handover = !stallreq_if && !rStall[0];
      if (handover) begin
        modelPc   = rBr ? rTgt : (modelPend ? modelRedir : modelPc + 32'd4);
        modelPend = 1'b0;
        consumed++;
      end else if (rBr) begin
        modelPend  = 1'b1;
        modelRedir = rTgt;
      end
      tick();
    end
    applyStimulus(6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("rndProgress", {31'b0, (consumed > 40)}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
